// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES types and constants for the decryption datapath.
//            state_t  - 128-bit AES state, byte 0 in the MSBs
//            byte_t   - single state byte
//            fsm_state_e - control states of the iterative InvSubBytes engine
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
// Module   : inv_sbox
// Purpose  : AES inverse S-box, pure combinational 256-entry lookup.
// Ports    : in_byte  (in,  8) - byte to substitute
//            out_byte (out, 8) - inverse S-box value of in_byte
// Revision : 1.0 - initial release
// ============================================================================
module inv_sbox
  import aes_pkg::*;
(
  input  byte_t in_byte,
  output byte_t out_byte
);

  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h52; 8'h01: out_byte = 8'h09; 8'h02: out_byte = 8'h6a; 8'h03: out_byte = 8'hd5; 8'h04: out_byte = 8'h30; 8'h05: out_byte = 8'h36; 8'h06: out_byte = 8'ha5; 8'h07: out_byte = 8'h38;
      8'h08: out_byte = 8'hbf; 8'h09: out_byte = 8'h40; 8'h0a: out_byte = 8'ha3; 8'h0b: out_byte = 8'h9e; 8'h0c: out_byte = 8'h81; 8'h0d: out_byte = 8'hf3; 8'h0e: out_byte = 8'hd7; 8'h0f: out_byte = 8'hfb;
      8'h10: out_byte = 8'h7c; 8'h11: out_byte = 8'he3; 8'h12: out_byte = 8'h39; 8'h13: out_byte = 8'h82; 8'h14: out_byte = 8'h9b; 8'h15: out_byte = 8'h2f; 8'h16: out_byte = 8'hff; 8'h17: out_byte = 8'h87;
      8'h18: out_byte = 8'h34; 8'h19: out_byte = 8'h8e; 8'h1a: out_byte = 8'h43; 8'h1b: out_byte = 8'h44; 8'h1c: out_byte = 8'hc4; 8'h1d: out_byte = 8'hde; 8'h1e: out_byte = 8'he9; 8'h1f: out_byte = 8'hcb;
      8'h20: out_byte = 8'h54; 8'h21: out_byte = 8'h7b; 8'h22: out_byte = 8'h94; 8'h23: out_byte = 8'h32; 8'h24: out_byte = 8'ha6; 8'h25: out_byte = 8'hc2; 8'h26: out_byte = 8'h23; 8'h27: out_byte = 8'h3d;
      8'h28: out_byte = 8'hee; 8'h29: out_byte = 8'h4c; 8'h2a: out_byte = 8'h95; 8'h2b: out_byte = 8'h0b; 8'h2c: out_byte = 8'h42; 8'h2d: out_byte = 8'hfa; 8'h2e: out_byte = 8'hc3; 8'h2f: out_byte = 8'h4e;
      8'h30: out_byte = 8'h08; 8'h31: out_byte = 8'h2e; 8'h32: out_byte = 8'ha1; 8'h33: out_byte = 8'h66; 8'h34: out_byte = 8'h28; 8'h35: out_byte = 8'hd9; 8'h36: out_byte = 8'h24; 8'h37: out_byte = 8'hb2;
      8'h38: out_byte = 8'h76; 8'h39: out_byte = 8'h5b; 8'h3a: out_byte = 8'ha2; 8'h3b: out_byte = 8'h49; 8'h3c: out_byte = 8'h6d; 8'h3d: out_byte = 8'h8b; 8'h3e: out_byte = 8'hd1; 8'h3f: out_byte = 8'h25;
      8'h40: out_byte = 8'h72; 8'h41: out_byte = 8'hf8; 8'h42: out_byte = 8'hf6; 8'h43: out_byte = 8'h64; 8'h44: out_byte = 8'h86; 8'h45: out_byte = 8'h68; 8'h46: out_byte = 8'h98; 8'h47: out_byte = 8'h16;
      8'h48: out_byte = 8'hd4; 8'h49: out_byte = 8'ha4; 8'h4a: out_byte = 8'h5c; 8'h4b: out_byte = 8'hcc; 8'h4c: out_byte = 8'h5d; 8'h4d: out_byte = 8'h65; 8'h4e: out_byte = 8'hb6; 8'h4f: out_byte = 8'h92;
      8'h50: out_byte = 8'h6c; 8'h51: out_byte = 8'h70; 8'h52: out_byte = 8'h48; 8'h53: out_byte = 8'h50; 8'h54: out_byte = 8'hfd; 8'h55: out_byte = 8'hed; 8'h56: out_byte = 8'hb9; 8'h57: out_byte = 8'hda;
      8'h58: out_byte = 8'h5e; 8'h59: out_byte = 8'h15; 8'h5a: out_byte = 8'h46; 8'h5b: out_byte = 8'h57; 8'h5c: out_byte = 8'ha7; 8'h5d: out_byte = 8'h8d; 8'h5e: out_byte = 8'h9d; 8'h5f: out_byte = 8'h84;
      8'h60: out_byte = 8'h90; 8'h61: out_byte = 8'hd8; 8'h62: out_byte = 8'hab; 8'h63: out_byte = 8'h00; 8'h64: out_byte = 8'h8c; 8'h65: out_byte = 8'hbc; 8'h66: out_byte = 8'hd3; 8'h67: out_byte = 8'h0a;
      8'h68: out_byte = 8'hf7; 8'h69: out_byte = 8'he4; 8'h6a: out_byte = 8'h58; 8'h6b: out_byte = 8'h05; 8'h6c: out_byte = 8'hb8; 8'h6d: out_byte = 8'hb3; 8'h6e: out_byte = 8'h45; 8'h6f: out_byte = 8'h06;
      8'h70: out_byte = 8'hd0; 8'h71: out_byte = 8'h2c; 8'h72: out_byte = 8'h1e; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'hca; 8'h75: out_byte = 8'h3f; 8'h76: out_byte = 8'h0f; 8'h77: out_byte = 8'h02;
      8'h78: out_byte = 8'hc1; 8'h79: out_byte = 8'haf; 8'h7a: out_byte = 8'hbd; 8'h7b: out_byte = 8'h03; 8'h7c: out_byte = 8'h01; 8'h7d: out_byte = 8'h13; 8'h7e: out_byte = 8'h8a; 8'h7f: out_byte = 8'h6b;
      8'h80: out_byte = 8'h3a; 8'h81: out_byte = 8'h91; 8'h82: out_byte = 8'h11; 8'h83: out_byte = 8'h41; 8'h84: out_byte = 8'h4f; 8'h85: out_byte = 8'h67; 8'h86: out_byte = 8'hdc; 8'h87: out_byte = 8'hea;
      8'h88: out_byte = 8'h97; 8'h89: out_byte = 8'hf2; 8'h8a: out_byte = 8'hcf; 8'h8b: out_byte = 8'hce; 8'h8c: out_byte = 8'hf0; 8'h8d: out_byte = 8'hb4; 8'h8e: out_byte = 8'he6; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h96; 8'h91: out_byte = 8'hac; 8'h92: out_byte = 8'h74; 8'h93: out_byte = 8'h22; 8'h94: out_byte = 8'he7; 8'h95: out_byte = 8'had; 8'h96: out_byte = 8'h35; 8'h97: out_byte = 8'h85;
      8'h98: out_byte = 8'he2; 8'h99: out_byte = 8'hf9; 8'h9a: out_byte = 8'h37; 8'h9b: out_byte = 8'he8; 8'h9c: out_byte = 8'h1c; 8'h9d: out_byte = 8'h75; 8'h9e: out_byte = 8'hdf; 8'h9f: out_byte = 8'h6e;
      8'ha0: out_byte = 8'h47; 8'ha1: out_byte = 8'hf1; 8'ha2: out_byte = 8'h1a; 8'ha3: out_byte = 8'h71; 8'ha4: out_byte = 8'h1d; 8'ha5: out_byte = 8'h29; 8'ha6: out_byte = 8'hc5; 8'ha7: out_byte = 8'h89;
      8'ha8: out_byte = 8'h6f; 8'ha9: out_byte = 8'hb7; 8'haa: out_byte = 8'h62; 8'hab: out_byte = 8'h0e; 8'hac: out_byte = 8'haa; 8'had: out_byte = 8'h18; 8'hae: out_byte = 8'hbe; 8'haf: out_byte = 8'h1b;
      8'hb0: out_byte = 8'hfc; 8'hb1: out_byte = 8'h56; 8'hb2: out_byte = 8'h3e; 8'hb3: out_byte = 8'h4b; 8'hb4: out_byte = 8'hc6; 8'hb5: out_byte = 8'hd2; 8'hb6: out_byte = 8'h79; 8'hb7: out_byte = 8'h20;
      8'hb8: out_byte = 8'h9a; 8'hb9: out_byte = 8'hdb; 8'hba: out_byte = 8'hc0; 8'hbb: out_byte = 8'hfe; 8'hbc: out_byte = 8'h78; 8'hbd: out_byte = 8'hcd; 8'hbe: out_byte = 8'h5a; 8'hbf: out_byte = 8'hf4;
      8'hc0: out_byte = 8'h1f; 8'hc1: out_byte = 8'hdd; 8'hc2: out_byte = 8'ha8; 8'hc3: out_byte = 8'h33; 8'hc4: out_byte = 8'h88; 8'hc5: out_byte = 8'h07; 8'hc6: out_byte = 8'hc7; 8'hc7: out_byte = 8'h31;
      8'hc8: out_byte = 8'hb1; 8'hc9: out_byte = 8'h12; 8'hca: out_byte = 8'h10; 8'hcb: out_byte = 8'h59; 8'hcc: out_byte = 8'h27; 8'hcd: out_byte = 8'h80; 8'hce: out_byte = 8'hec; 8'hcf: out_byte = 8'h5f;
      8'hd0: out_byte = 8'h60; 8'hd1: out_byte = 8'h51; 8'hd2: out_byte = 8'h7f; 8'hd3: out_byte = 8'ha9; 8'hd4: out_byte = 8'h19; 8'hd5: out_byte = 8'hb5; 8'hd6: out_byte = 8'h4a; 8'hd7: out_byte = 8'h0d;
      8'hd8: out_byte = 8'h2d; 8'hd9: out_byte = 8'he5; 8'hda: out_byte = 8'h7a; 8'hdb: out_byte = 8'h9f; 8'hdc: out_byte = 8'h93; 8'hdd: out_byte = 8'hc9; 8'hde: out_byte = 8'h9c; 8'hdf: out_byte = 8'hef;
      8'he0: out_byte = 8'ha0; 8'he1: out_byte = 8'he0; 8'he2: out_byte = 8'h3b; 8'he3: out_byte = 8'h4d; 8'he4: out_byte = 8'hae; 8'he5: out_byte = 8'h2a; 8'he6: out_byte = 8'hf5; 8'he7: out_byte = 8'hb0;
      8'he8: out_byte = 8'hc8; 8'he9: out_byte = 8'heb; 8'hea: out_byte = 8'hbb; 8'heb: out_byte = 8'h3c; 8'hec: out_byte = 8'h83; 8'hed: out_byte = 8'h53; 8'hee: out_byte = 8'h99; 8'hef: out_byte = 8'h61;
      8'hf0: out_byte = 8'h17; 8'hf1: out_byte = 8'h2b; 8'hf2: out_byte = 8'h04; 8'hf3: out_byte = 8'h7e; 8'hf4: out_byte = 8'hba; 8'hf5: out_byte = 8'h77; 8'hf6: out_byte = 8'hd6; 8'hf7: out_byte = 8'h26;
      8'hf8: out_byte = 8'he1; 8'hf9: out_byte = 8'h69; 8'hfa: out_byte = 8'h14; 8'hfb: out_byte = 8'h63; 8'hfc: out_byte = 8'h55; 8'hfd: out_byte = 8'h21; 8'hfe: out_byte = 8'h0c; 8'hff: out_byte = 8'h7d;
      default: out_byte = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_seq
// Purpose  : Iterative AES InvSubBytes engine. Captures a 128-bit state on an
//            input valid/ready handshake, substitutes LANES bytes per cycle
//            through LANES inverse S-boxes, and presents the result on an
//            output valid/ready handshake.
// Ports    : clk       (in,    1) - rising-edge clock
//            rst       (in,    1) - synchronous active-high reset
//            in_valid  (in,    1) - in_data offered
//            in_ready  (out,   1) - engine idle, can accept a state
//            in_data   (in,  128) - input state, byte 0 in bits [127:120]
//            out_valid (out,   1) - out_data holds a finished result
//            out_ready (in,    1) - consumer accepts out_data
//            out_data  (out, 128) - inverse-substituted state
// Params   : LANES - bytes substituted per cycle (1, 2, 4, 8 or 16)
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int STEPS = AES_STATE_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int GRP_W = 8 * LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  fsm_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           data_q, data_d;

  // Group of LANES bytes currently being substituted, and its S-box results.
  logic [GRP_W-1:0] grp_in;
  logic [GRP_W-1:0] grp_out;

  // Group g holds bytes g*LANES .. g*LANES+LANES-1; byte 0 sits in the MSBs,
  // so group g occupies the slice counted down from the top of the state.
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < STEPS; g++) begin
      if (cnt_q == CNT_W'(g)) begin
        grp_in = data_q[(STEPS-1-g)*GRP_W +: GRP_W];
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    inv_sbox u_inv_sbox (
      .in_byte  (grp_in [GRP_W-1-8*j -: 8]),
      .out_byte (grp_out[GRP_W-1-8*j -: 8])
    );
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = '0;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < STEPS; g++) begin
          if (cnt_q == CNT_W'(g)) begin
            data_d[(STEPS-1-g)*GRP_W +: GRP_W] = grp_out;
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  // Handshake flags depend on the registered state only.
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign out_data  = data_q;

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Iterative AES InvSubBytes engine for the decryption datapath. It accepts a 128-bit state on a valid/ready handshake and replaces every byte with its inverse S-box value, LANES bytes per cycle. It returns the result on a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse round and is the decryption-side counterpart of the forward S-box lookup.

## Interface
- LANES, 4, number of inverse S-box instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is offered.
- in_ready  out  1  block can accept a state; high only in IDLE.
- in_data  in  128  input state; byte i = in_data[127-8i -: 8], so byte 0 is the MSB.
- out_valid  out  1  out_data holds a completed result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  inverse-substituted state, same byte order as the input.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the state register, clear the byte counter, and go to BUSY.
  - BUSY: each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced in place by inv_sbox(byte), and cnt increments. When cnt == 16/LANES-1, go to DONE on that edge.
  - DONE: out_valid=1 and out_data = state register. On out_ready, go to IDLE. While out_ready=0, out_data holds unchanged.
- The counter width is clog2(16/LANES), with a minimum of 1 bit. The counter wraps only through re-capture; it never increments outside BUSY.
- in_valid is ignored outside IDLE. in_data is sampled only at the handshake edge, so later changes to in_data have no effect.
- out_ready is ignored outside DONE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. Both are decoded from the FSM state only.
- Each inverse S-box is pure combinational, 256 entries, and exactly the inverse of the AES forward S-box (inv(0x63)=0x00, inv(0x00)=0x52, inv(0x16)=0xff).
- Reset mid-operation: the current block is discarded, and the engine returns to IDLE on the next edge with no output produced.
- Reset values: FSM=IDLE, counter=0, state register=0. Outputs: in_ready=1 in the first cycle after reset, out_valid=0, out_data=0.

## Timing
- Input handshake at edge T.
- The BUSY transforms occur on edges T+1 … T+16/LANES.
- out_valid=1 from edge T+16/LANES (T+4 for LANES=4).
- If out_ready=1 while out_valid=1 at edge D:
  - out_valid=0 after D.
  - in_ready=1 after D.
  - The next input is accepted no earlier than edge D+1.
- Maximum throughput is one block per 16/LANES+2 cycles (6 for LANES=4).
- Latency is fixed and independent of data values.

## Structure
- Shared package aes_pkg:
  - state_t (128-bit) and byte_t types.
  - AES_STATE_BYTES=16.
  - The FSM state enum: IDLE, BUSY, DONE.
- Sub-module inv_sbox (8-bit in, 8-bit out, combinational case table), instantiated LANES times via generate.
- The top level holds the FSM, the counter, and the 128-bit state register, with lane muxing on the counter.

## Test plan
- **Reset defaults:** assert rst for 2 cycles with random inputs → in_ready=1, out_valid=0, out_data=0 after release.
- **All-0x63 state:** in_data all bytes 0x63, out_ready=1 → out_valid exactly 4 cycles after the handshake, out_data=0x0000…00, returns to IDLE next cycle.
- **Ordered vector:** in_data=0x637c777bf26b6fc53001672bfed7ab76 → out_data=0x000102030405060708090a0b0c0d0e0f, confirming the byte order.
- **Backpressure:**
  - out_ready=0 for 10 cycles after out_valid → out_data stable and in_ready=0 throughout.
  - Raising out_ready → one transfer, then in_ready=1.
- **Mid-block reset:** pulse rst during the second BUSY cycle → no out_valid. A subsequent input of all 0x16 yields all 0xff with normal latency.
- **Back-to-back blocks:** in_valid held high with out_ready=1 and two states → in_data changes are ignored while busy. Results match the software inverse S-box model; throughput is one block per 6 cycles. Repeat for LANES=1 (latency 16) and LANES=16 (latency 1).
